dm_bus_arbiter: RTL and testbench

- Shares the single data-memory/GPIO bus of the peripheral block between two masters.
  - m0: CPU data port.
  - m1: boot/debug loader (DMA-style writer/reader).
- Accepts req/ack handshakes, selects one master per transaction (round-robin or fixed priority) and sequences the bus strobes.
- Captures read data and returns it with a one-cycle ack pulse. Sits between the masters and the peripheral's dm_w/dm_r/addr/wdata/dm_op/rdata port.

---
 rtl/dm_bus_arbiter.sv | 121 ++++++++++++
 tb/tb_dm_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter for the peripheral data-memory/GPIO bus.
// Each transaction goes IDLE -> BUSY (one strobe cycle) -> ACK (one ack cycle).
module dm_bus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [2:0]    m0_op,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [2:0]    m1_op,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          dm_w,
  output logic          dm_r,
  output logic [DW-1:0] addr,
  output logic [DW-1:0] wdata,
  output logic [2:0]    dm_op,
  input  logic [DW-1:0] rdata,
  output logic          busy,
  output logic          last_grant
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e        state_q;
  logic          grant_q;
  logic          grant_d;
  logic          last_grant_q;
  logic          m0_ack_q;
  logic          m1_ack_q;
  logic [DW-1:0] m0_rdata_q;
  logic [DW-1:0] m1_rdata_q;

  logic          sel_we;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [2:0]    sel_op;
  logic          in_busy;

  // A tie goes to m0 under fixed priority, otherwise to whoever did not win last.
  always_comb begin
    grant_d = grant_q;
    if (m0_req && m1_req) begin
      grant_d = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else if (m1_req) begin
      grant_d = 1'b1;
    end else if (m0_req) begin
      grant_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      m0_ack_q     <= 1'b0;
      m1_ack_q     <= 1'b0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q      <= BUSY;
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
          end
        end
        BUSY: begin
          state_q <= ACK;
          if (grant_q) begin
            m1_ack_q <= 1'b1;
            if (!sel_we) m1_rdata_q <= rdata;
          end else begin
            m0_ack_q <= 1'b1;
            if (!sel_we) m0_rdata_q <= rdata;
          end
        end
        ACK: begin
          state_q  <= IDLE;
          m0_ack_q <= 1'b0;
          m1_ack_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus drive is combinational from the held grant so reset kills strobes at once.
  always_comb begin
    sel_we    = grant_q ? m1_we    : m0_we;
    sel_addr  = grant_q ? m1_addr  : m0_addr;
    sel_wdata = grant_q ? m1_wdata : m0_wdata;
    sel_op    = grant_q ? m1_op    : m0_op;
    in_busy   = (state_q == BUSY);
  end

  assign dm_w       = in_busy && sel_we;
  assign dm_r       = in_busy && !sel_we;
  assign addr       = in_busy ? sel_addr  : '0;
  assign wdata      = in_busy ? sel_wdata : '0;
  assign dm_op      = in_busy ? sel_op    : 3'd0;
  assign busy       = (state_q != IDLE);
  assign last_grant = last_grant_q;
  assign m0_ack     = m0_ack_q;
  assign m1_ack     = m1_ack_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter: a round-robin instance with a small memory/GPIO
// peripheral model, and a fixed-priority instance with an address-derived read model.
module tb_dm_bus_arbiter;

  localparam logic [2:0]  DM_OP_WD = 3'd1;
  localparam logic [2:0]  DM_OP_SB = 3'd2;
  localparam logic [2:0]  DM_OP_BS = 3'd3;
  localparam logic [2:0]  DM_OP_BZ = 3'd4;
  localparam logic [31:0] LED_ADDR = 32'hBF80_0000;
  localparam logic [31:0] SW_ADDR  = 32'hBF80_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic        m0Req = 0, m0We = 0, m1Req = 0, m1We = 0;
  logic [31:0] m0Addr = 0, m0Wdata = 0, m1Addr = 0, m1Wdata = 0;
  logic [2:0]  m0Op = 0, m1Op = 0;
  logic        m0Ack, m1Ack, dmW, dmR, busy, lastGrant;
  logic [31:0] m0Rdata, m1Rdata, busAddr, busWdata;
  logic [31:0] rdata = 32'h0;
  logic [2:0]  dmOp;

  // Fixed-priority instance signals
  logic        p0Req = 0, p0We = 0, p1Req = 0, p1We = 0;
  logic [31:0] p0Addr = 0, p0Wdata = 0, p1Addr = 0, p1Wdata = 0;
  logic [2:0]  p0Op = 0, p1Op = 0;
  logic        p0Ack, p1Ack, qDmW, qDmR, qBusy, qLastGrant;
  logic [31:0] p0Rdata, p1Rdata, qAddr, qWdata;
  logic [31:0] qRdata = 32'h0;
  logic [2:0]  qOp;

  dm_bus_arbiter #(.FIXED_PRIO(1'b0), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata), .m0_op(m0Op),
    .m0_ack(m0Ack), .m0_rdata(m0Rdata),
    .m1_req(m1Req), .m1_we(m1We), .m1_addr(m1Addr), .m1_wdata(m1Wdata), .m1_op(m1Op),
    .m1_ack(m1Ack), .m1_rdata(m1Rdata),
    .dm_w(dmW), .dm_r(dmR), .addr(busAddr), .wdata(busWdata), .dm_op(dmOp),
    .rdata(rdata), .busy(busy), .last_grant(lastGrant)
  );

  dm_bus_arbiter #(.FIXED_PRIO(1'b1), .DW(32)) dutFp (
    .clk(clk), .rst(rst),
    .m0_req(p0Req), .m0_we(p0We), .m0_addr(p0Addr), .m0_wdata(p0Wdata), .m0_op(p0Op),
    .m0_ack(p0Ack), .m0_rdata(p0Rdata),
    .m1_req(p1Req), .m1_we(p1We), .m1_addr(p1Addr), .m1_wdata(p1Wdata), .m1_op(p1Op),
    .m1_ack(p1Ack), .m1_rdata(p1Rdata),
    .dm_w(qDmW), .dm_r(qDmR), .addr(qAddr), .wdata(qWdata), .dm_op(qOp),
    .rdata(qRdata), .busy(qBusy), .last_grant(qLastGrant)
  );

  // Peripheral model: word memory, byte store, LED register and switch input
  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic [7:0]  ioLed = 8'h0;
  logic [15:0] ioSwitch = 16'h0;

  always @(posedge clk) begin
    if (dmW) begin
      if (busAddr == LED_ADDR) ioLed <= busWdata[7:0];
      else if (dmOp == DM_OP_SB) mem[busAddr[7:2]][{busAddr[1:0], 3'b000} +: 8] <= busWdata[7:0];
      else mem[busAddr[7:2]] <= busWdata;
    end
  end

  function automatic logic [31:0] periphRead(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] w;
    logic [7:0]  b;
    w = (a == SW_ADDR) ? {16'h0, ioSwitch} : mem[a[7:2]];
    b = w[{a[1:0], 3'b000} +: 8];
    if (op == DM_OP_BS) return {{24{b[7]}}, b};
    if (op == DM_OP_BZ) return {24'h0, b};
    return w;
  endfunction

  always @(negedge clk) if (dmR) rdata <= periphRead(busAddr, dmOp);
  always @(negedge clk) if (qDmR) qRdata <= qAddr ^ 32'hA5A5_0000;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  logic        capW, capR, capOther, capAckAfter;
  logic [31:0] capAddr, capWdata;
  logic [2:0]  capOp;

  // One transaction on the round-robin instance; bus captured mid-BUSY, ack latency in negedges
  task automatic applyStimulus(input int m, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] op,
                               output logic [31:0] rd, output int lat);
    @(negedge clk);
    if (m == 0) begin m0Req = 1; m0We = we; m0Addr = a; m0Wdata = wd; m0Op = op; end
    else        begin m1Req = 1; m1We = we; m1Addr = a; m1Wdata = wd; m1Op = op; end
    lat = -1;
    capOther = 1'b0;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if (i == 1) begin
        capW = dmW; capR = dmR; capAddr = busAddr; capWdata = busWdata; capOp = dmOp;
      end
      if ((m == 0 && m0Ack) || (m == 1 && m1Ack)) begin
        lat = i;
        capOther = (m == 0) ? m1Ack : m0Ack;
      end
    end
    rd = (m == 0) ? m0Rdata : m1Rdata;
    if (m == 0) m0Req = 0; else m1Req = 0;
    @(negedge clk);
    capAckAfter = m0Ack | m1Ack;
  endtask

  logic [31:0] rd;
  int lat;

  initial begin
    int k, c, prevC, who, cnt0, cnt1, fpM0, fpM1Cycle, fpM0AtM1;
    ioSwitch = 16'h00F3;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstLastGrant", 32'(lastGrant), 32'd1);
    checkOutput("rstAcks", 32'({m0Ack, m1Ack}), 32'd0);
    checkOutput("rstRdata", m0Rdata | m1Rdata, 32'd0);

    // Reset during a write's BUSY cycle
    m0Req = 1; m0We = 1; m0Addr = 32'h40; m0Wdata = 32'h1234_5678; m0Op = DM_OP_WD;
    @(negedge clk);
    checkOutput("abortPreW", 32'(dmW), 32'd1);
    #2 rst = 1;
    #1 checkOutput("abortDmW", 32'(dmW), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("abortNoAck", 32'(m0Ack), 32'd0);
    m0Req = 0;
    rst = 0;
    @(negedge clk);
    checkOutput("postRstBus", busAddr | busWdata | 32'(dmOp) | 32'({dmW, dmR}), 32'd0);
    checkOutput("postRstLast", 32'(lastGrant), 32'd1);
    checkOutput("postRstAck", 32'({m0Ack, m1Ack}), 32'd0);
    checkOutput("abortMemUntouched", mem[16], 32'd0);

    // Single write then readback
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, DM_OP_WD, rd, lat);
    checkOutput("wrLatency", 32'(lat), 32'd2);
    checkOutput("wrStrobes", 32'({capW, capR}), 32'b10);
    checkOutput("wrAddr", capAddr, 32'h10);
    checkOutput("wrData", capWdata, 32'hDEAD_BEEF);
    checkOutput("wrOp", 32'(capOp), 32'(DM_OP_WD));
    checkOutput("wrOtherAck", 32'(capOther), 32'd0);
    checkOutput("wrAckPulse", 32'(capAckAfter), 32'd0);
    checkOutput("wrRdataHeld", rd, 32'd0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, DM_OP_WD, rd, lat);
    checkOutput("rdLatency", 32'(lat), 32'd2);
    checkOutput("rdStrobes", 32'({capW, capR}), 32'b01);
    checkOutput("rdData", rd, 32'hDEAD_BEEF);

    // GPIO path
    applyStimulus(1, 1'b1, LED_ADDR, 32'h5A, DM_OP_WD, rd, lat);
    checkOutput("ledAckLat", 32'(lat), 32'd2);
    checkOutput("ledValue", 32'(ioLed), 32'h5A);
    applyStimulus(0, 1'b0, SW_ADDR, 32'h0, DM_OP_WD, rd, lat);
    checkOutput("swRead", rd, 32'h0000_00F3);
    checkOutput("swM1Untouched", m1Rdata, 32'd0);

    // Byte store and sign/zero-extending loads
    applyStimulus(1, 1'b1, 32'h20, 32'h0000_0081, DM_OP_SB, rd, lat);
    checkOutput("sbOp", 32'(capOp), 32'(DM_OP_SB));
    applyStimulus(0, 1'b0, 32'h20, 32'h0, DM_OP_BS, rd, lat);
    checkOutput("loadBS", rd, 32'hFFFF_FF81);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, DM_OP_BZ, rd, lat);
    checkOutput("loadBZ", rd, 32'h0000_0081);

    // Round-robin contention: 4 reads each, reqs held high
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
    m0Req = 1; m0We = 0; m0Addr = 32'h10; m0Op = DM_OP_WD;
    m1Req = 1; m1We = 0; m1Addr = 32'h20; m1Op = DM_OP_WD;
    k = 0; prevC = 0; cnt0 = 0; cnt1 = 0;
    for (c = 1; c <= 40 && k < 8; c++) begin
      @(negedge clk);
      if (m0Ack || m1Ack) begin
        who = m1Ack ? 1 : 0;
        checkOutput($sformatf("rrOwner%0d", k), 32'(who), 32'(k % 2));
        checkOutput($sformatf("rrSingleAck%0d", k), 32'({m0Ack, m1Ack} == 2'b11), 32'd0);
        checkOutput($sformatf("rrSpacing%0d", k), 32'(c - prevC), (k == 0) ? 32'd2 : 32'd3);
        if (who == 0) begin
          checkOutput($sformatf("rrData%0d", k), m0Rdata, 32'hDEAD_BEEF);
          cnt0++;
          if (cnt0 == 4) m0Req = 0;
        end else begin
          checkOutput($sformatf("rrData%0d", k), m1Rdata, 32'h0000_0081);
          cnt1++;
          if (cnt1 == 4) m1Req = 0;
        end
        prevC = c;
        k++;
      end
    end
    m0Req = 0; m1Req = 0;
    checkOutput("rrCount", 32'(k), 32'd8);

    // Fixed priority: m0 wins every tie until it drops its request
    @(negedge clk);
    p0Req = 1; p0Addr = 32'h100; p0Op = DM_OP_WD;
    p1Req = 1; p1Addr = 32'h200; p1Op = DM_OP_WD;
    fpM0 = 0; fpM1Cycle = -1; fpM0AtM1 = -1;
    for (c = 1; c <= 40 && fpM1Cycle < 0; c++) begin
      @(negedge clk);
      if (p0Ack) begin
        checkOutput($sformatf("fpM0Cycle%0d", fpM0), 32'(c), 32'(2 + 3 * fpM0));
        fpM0++;
        if (fpM0 == 3) p0Req = 0;
      end
      if (p1Ack) begin
        fpM1Cycle = c;
        fpM0AtM1 = fpM0;
        p1Req = 0;
      end
    end
    p0Req = 0; p1Req = 0;
    checkOutput("fpM1Cycle", 32'(fpM1Cycle), 32'd11);
    checkOutput("fpM0Before", 32'(fpM0AtM1), 32'd3);
    checkOutput("fpM0Rdata", p0Rdata, 32'hA5A5_0100);
    checkOutput("fpM1Rdata", p1Rdata, 32'hA5A5_0200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
